imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//   Write-side companion of the instruction memory: takes a byte stream (valid/ready), assembles
//   little-endian 32-bit words and writes them sequentially into the instruction RAM write port.
//   Holds the CPU while loading, so a program can be replaced at run time.
//   Sits between the boot/UART byte source and the instruction memory.
// PARAMETERS
//   DATA_WIDTH  32   instruction word width (fixed at 32; 4 bytes per word)
//   ADDR_WIDTH  32   byte-address width of imem_waddr
//   MEM_SIZE    512  instruction RAM depth in words; upper bound on words accepted
// PORTS
//   clk          in   1           rising-edge clock
//   rst_n        in   1           asynchronous active-low reset
//   start        in   1           1-cycle pulse: begin a load (honoured in IDLE, DONE, ERR only)
//   byte_in      in   8           stream byte
//   byte_valid   in   1           byte_in valid
//   byte_ready   out  1           loader accepts byte_in this cycle (transfer = valid & ready)
//   imem_we      out  1           instruction RAM write enable, 1 cycle per word
//   imem_waddr   out  ADDR_WIDTH  byte address of the write, word-aligned (word_idx << 2)
//   imem_wdata   out  DATA_WIDTH  assembled instruction word
//   cpu_hold     out  1           CPU stall/reset request while loading
//   done         out  1           last load completed successfully (level)
//   err          out  1           last load rejected (bad length) (level)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; byte_ready, imem_we, cpu_hold, done, err = 0;
//   imem_waddr = 0, imem_wdata = 0; byte/word counters cleared. Reset mid-load aborts the load;
//   words already written stay in RAM.
// - Stream format: 2-byte little-endian word count N, followed by N words, 4 bytes each, LSB first
//   (first byte -> bits [7:0]).
// - States:
//   IDLE  -> LEN0 on start
//   LEN0  ready=1; on transfer latch N[7:0]                   -> LEN1
//   LEN1  ready=1; on transfer latch N[15:8]; the check uses the full N including this byte:
//         N==0 or N>MEM_SIZE -> ERR, else                     -> DATA
//   DATA  ready=1; on transfer shift the byte into lane byte_cnt; on 4th byte (byte_cnt==3)
//                                                              -> WRITE
//   WRITE ready=0; imem_we=1 for exactly 1 cycle with waddr/wdata stable;
//         word_idx==N-1 -> DONE, else word_idx++, byte_cnt=0  -> DATA
//   DONE  done=1; start -> LEN0 (done cleared)
//   ERR   err=1; start -> LEN0 (err cleared)
// - cpu_hold=1 in LEN0, LEN1, DATA, WRITE; 0 in IDLE, DONE, ERR. It drops in the cycle after
//   the last write.
// - imem_we is registered; it never asserts outside WRITE. Exactly N write pulses per good load.
//   Addresses are 0, 4, ..., 4(N-1).
// - byte_valid while byte_ready=0 is not consumed; the source must hold the byte.
// - start during LEN0..WRITE is ignored.
// - Max throughput: 1 word per 5 cycles.
// TESTING
//   1. Reset then start; stream 01 00 13 05 A0 00 -> single imem_we, waddr=0x0, wdata=0x00A00513,
//      done=1, cpu_hold high LEN0..WRITE only.
//   2. N=3 with byte_valid toggled randomly -> 3 writes at 0x0/0x4/0x8 with correct data; no byte
//      lost or duplicated; byte_ready=0 during each WRITE cycle.
//   3. Length 00 00 -> err=1, no imem_we. Length 0x0201 (513 > 512) -> err=1, no writes.
//      Length 0x0200 -> 512 writes, last waddr=0x7FC.
//   4. rst_n low after 2 of 4 words -> all outputs 0 at once (async). Then start plus full stream
//      -> correct load from address 0.
//   5. start pulsed during DATA -> ignored, load completes normally. start in DONE -> new load,
//      done clears.
//   6. Loader writes into the instruction memory model, CPU released -> fetched instructions
//      match the streamed image.

Source files
------------

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Groups the two buses the instruction-memory loader works between:
//   the incoming byte stream (valid/ready) and the instruction RAM write port.
//
//   byte_in     [7:0]            stream byte               (source -> loader)
//   byte_valid                   byte_in valid             (source -> loader)
//   byte_ready                   loader accepts byte_in    (loader -> source)
//   imem_we                      RAM write enable          (loader -> RAM)
//   imem_waddr  [ADDR_WIDTH-1:0] word-aligned byte address (loader -> RAM)
//   imem_wdata  [DATA_WIDTH-1:0] assembled word            (loader -> RAM)
//
//   master : the loader side
//   slave  : the byte source / RAM side
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [DATA_WIDTH-1:0] imem_wdata;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Write-side companion of the instruction memory. Accepts a byte stream made
//   of a 2-byte little-endian word count N followed by N little-endian 32-bit
//   words, and writes the words to instruction RAM at byte addresses
//   0, 4, ..., 4(N-1). The CPU is held while a load is in progress so the
//   program can be replaced at run time. A count of 0 or above MEM_SIZE is
//   rejected without any write.
//
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (aborts a load in progress)
//   start     in   1-cycle pulse, begins a load from IDLE, DONE or ERR
//   cpu_hold  out  high while loading (LEN0, LEN1, DATA, WRITE)
//   done      out  last load completed (level)
//   err       out  last load rejected for a bad length (level)
//   bus       imem_loader_if.master: byte stream in, RAM write port out
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  imem_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q;
  logic [15:0]           word_idx_q;
  logic [1:0]            byte_cnt_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic        xfer;
  logic        start_ok;
  logic        len_bad;
  logic        last_word;
  logic [15:0] len_full;

  assign xfer      = bus.byte_valid & bus.byte_ready;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  // The length check in LEN1 must see the high byte arriving this cycle,
  // not the not-yet-updated register.
  assign len_full  = {bus.byte_in, len_q[7:0]};
  assign len_bad   = (len_full == 16'd0) || (32'(len_full) > 32'(MEM_SIZE));
  assign last_word = (word_idx_q == len_q - 16'd1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each always_comb keeps every
  // path assigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_d = S_LEN0;
      S_LEN0:  if (xfer) state_d = S_LEN1;
      S_LEN1:  if (xfer) state_d = len_bad ? S_ERR : S_DATA;
      S_DATA:  if (xfer && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_DONE : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decode of the state register (glitch-free per cycle, and all
  // zero in IDLE, which is also the reset state).
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.byte_ready = 1'b0;
    bus.imem_we    = 1'b0;
    cpu_hold       = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    unique case (state_q)
      S_LEN0, S_LEN1, S_DATA: begin
        bus.byte_ready = 1'b1;
        cpu_hold       = 1'b1;
      end
      S_WRITE: begin
        bus.imem_we = 1'b1;
        cpu_hold    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: length, byte lane, word index and word assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      wdata_q    <= '0;
    end else begin
      if (start_ok) begin
        word_idx_q <= '0;
        byte_cnt_q <= '0;
      end
      unique case (state_q)
        S_LEN0: if (xfer) len_q[7:0]  <= bus.byte_in;
        S_LEN1: if (xfer) len_q[15:8] <= bus.byte_in;
        S_DATA: if (xfer) begin
          wdata_q[{byte_cnt_q, 3'b000} +: 8] <= bus.byte_in;
          // Wraps 3 -> 0, so the lane counter is ready for the next word
          // when WRITE hands back to DATA.
          byte_cnt_q <= byte_cnt_q + 2'd1;
        end
        // The index stays on the last word after DONE so waddr keeps showing
        // the final write address.
        S_WRITE: if (!last_word) word_idx_q <= word_idx_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.imem_waddr = ADDR_WIDTH'({word_idx_q, 2'b00});
  assign bus.imem_wdata = wdata_q;

endmodule
